// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared definitions for the MEM-stage load/store unit: load
//               mode encodings, byte counts, FSM state type and the request
//               legality check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    // Pipeline data path is architecturally 32 bits wide.
    localparam int DATA_W = 32;

    // load_mode encodings; also select the store size (00 word, else half).
    localparam logic [1:0] LM_WORD   = 2'b00;
    localparam logic [1:0] LM_HALF_S = 2'b01;
    localparam logic [1:0] LM_HALF_U = 2'b10;
    localparam logic [1:0] LM_RSVD   = 2'b11;

    // Number of single-byte RAM accesses per request size.
    localparam logic [2:0] BYTES_WORD = 3'd4;
    localparam logic [2:0] BYTES_HALF = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // A request is rejected when it is neither a clean load nor a clean store,
    // uses the reserved mode on a load, or is not naturally aligned.
    function automatic logic lsu_req_err(
        input logic       rd,
        input logic       wr,
        input logic [1:0] mode,
        input logic [1:0] addr_lo
    );
        logic is_word;
        logic misaligned;
        is_word    = (mode == LM_WORD);
        misaligned = is_word ? (addr_lo != 2'b00) : addr_lo[0];
        return (rd == wr) || (rd && (mode == LM_RSVD)) || misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Pipeline-side request/response bundle of the load/store unit.
// Signals     : req_valid/req_ready handshake, mem_read, mem_write, load_mode,
//               address, write_data (request); read_data, resp_valid,
//               resp_err (response).
// Modports    : master = pipeline, slave = load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    import mips_mem_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          load_mode;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   read_data;
    logic                resp_valid;
    logic                resp_err;

    modport master (
        output req_valid, mem_read, mem_write, load_mode, address, write_data,
        input  req_ready, read_data, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, mem_read, mem_write, load_mode, address, write_data,
        output req_ready, read_data, resp_valid, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_extend
// Description : Combinational big-endian assembly and sign/zero extension of
//               captured load bytes (b0 is the most-significant byte).
// Ports       : b0..b3 - captured bytes, mode - load mode,
//               data    - 32-bit extended load result.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
    import mips_mem_pkg::*;
(
    input  wire logic [7:0]        b0,
    input  wire logic [7:0]        b1,
    input  wire logic [7:0]        b2,
    input  wire logic [7:0]        b3,
    input  wire logic [1:0]        mode,
    output logic      [DATA_W-1:0] data
);

    always_comb begin
        data = {b0, b1, b2, b3};
        case (mode)
            LM_WORD:   data = {b0, b1, b2, b3};
            LM_HALF_S: data = {{16{b0[7]}}, b0, b1};
            default:   data = {16'h0000, b0, b1};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Serialises one word/halfword load or store into big-endian
//               single-byte accesses on a byte-wide synchronous RAM, then
//               returns the extended load data or store completion with a
//               one-cycle response pulse.
// Ports       : clk, reset (sync, active high)
//               bus       - pipeline request/response (slave modport)
//               ram_en/ram_we/ram_addr/ram_wdata - registered RAM strobes
//               ram_rdata - RAM read byte, valid the cycle after a read
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    load_store_unit_if.slave       bus,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [7:0]             ram_wdata,
    input  wire logic [7:0]        ram_rdata
);

    lsu_state_t          r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_read_data;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [7:0]          r_ram_wdata;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [31:0]         r_wshift;     // remaining store bytes, next at [31:24]
    logic [2:0]          r_remain;     // bytes still to issue after current
    logic                r_is_load;
    logic [1:0]          r_mode;
    logic [3:0][7:0]     r_bytes;      // captured load bytes, index = k
    logic [1:0]          r_cap_idx;
    logic                r_rd_vld;     // ram_rdata holds a byte this cycle

    logic                w_req_err;
    logic                w_is_word;
    logic [2:0]          w_nbytes;
    logic [31:0]         w_wshift_init;
    logic [3:0][7:0]     w_bytes;
    logic [DATA_W-1:0]   w_ext_data;

    assign w_req_err     = lsu_req_err(bus.mem_read, bus.mem_write,
                                       bus.load_mode, bus.address[1:0]);
    assign w_is_word     = (bus.load_mode == LM_WORD);
    assign w_nbytes      = w_is_word ? BYTES_WORD : BYTES_HALF;
    // Half stores are left-justified so both sizes shift out from [31:24].
    assign w_wshift_init = w_is_word ? bus.write_data
                                     : {bus.write_data[15:0], 16'h0000};

    // Bytes as they will be after this cycle's capture; the final byte is
    // captured in DRAIN and must feed the result registered on that edge.
    always_comb begin
        w_bytes = r_bytes;
        if (r_rd_vld) begin
            w_bytes[r_cap_idx] = ram_rdata;
        end
    end

    lsu_extend u_extend (
        .b0   (w_bytes[0]),
        .b1   (w_bytes[1]),
        .b2   (w_bytes[2]),
        .b3   (w_bytes[3]),
        .mode (r_mode),
        .data (w_ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_read_data  <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 8'h00;
            r_next_addr  <= '0;
            r_wshift     <= '0;
            r_remain     <= 3'd0;
            r_is_load    <= 1'b0;
            r_mode       <= LM_WORD;
            r_bytes      <= '0;
            r_cap_idx    <= 2'd0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_vld     <= r_ram_en & ~r_ram_we;
            if (r_rd_vld) begin
                r_bytes   <= w_bytes;
                r_cap_idx <= r_cap_idx + 2'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_read_data  <= '0;
                        end else begin
                            // Byte 0 goes out on the acceptance edge.
                            r_state     <= ST_ISSUE;
                            r_is_load   <= bus.mem_read;
                            r_mode      <= bus.load_mode;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= bus.mem_write;
                            r_ram_addr  <= bus.address;
                            r_ram_wdata <= w_wshift_init[31:24];
                            r_wshift    <= {w_wshift_init[23:0], 8'h00};
                            r_next_addr <= bus.address + ADDR_W'(1);
                            r_remain    <= w_nbytes - 3'd1;
                            r_cap_idx   <= 2'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_remain != 3'd0) begin
                        r_ram_addr  <= r_next_addr;
                        r_ram_wdata <= r_wshift[31:24];
                        r_wshift    <= {r_wshift[23:0], 8'h00};
                        r_next_addr <= r_next_addr + ADDR_W'(1);
                        r_remain    <= r_remain - 3'd1;
                    end else begin
                        r_ram_en <= 1'b0;
                        r_ram_we <= 1'b0;
                        if (r_is_load) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_read_data  <= w_ext_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_en         = r_ram_en;
    assign ram_we         = r_ram_we;
    assign ram_addr       = r_ram_addr;
    assign ram_wdata      = r_ram_wdata;
    assign bus.req_ready  = r_req_ready;
    assign bus.read_data  = r_read_data;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Requests are driven
//               from a stimulus process which pushes the expected response
//               (from a byte-array reference model) into a scoreboard queue;
//               a monitor pops and compares on every resp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import mips_mem_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        rdata_q = 8'h00;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency (bench addresses stay below 4 KiB).
    bit [7:0] ram [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
            else        rdata_q <= ram[ram_addr[11:0]];
        end
    end
    assign ram_rdata = rdata_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          err;
        logic [31:0] data;
        int          acc;
        int          lat;
        int          nbytes;
    } exp_t;

    exp_t        sbq[$];
    bit [7:0]    mdl_mem [4096];
    logic [31:0] mdl_held;

    function automatic exp_t model(bit rd, bit wr, bit [1:0] mode,
                                   int unsigned addr, logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [31:0] v;
        n     = (mode == 2'b00) ? 4 : 2;
        e.err = (rd == wr) || (rd && mode == 2'b11) || (addr % n != 0);
        e.acc = 0;
        if (e.err) begin
            mdl_held = 32'h0;
            e.data   = 32'h0;
            e.lat    = 1;
            e.nbytes = 0;
        end else if (wr) begin
            for (int k = 0; k < n; k++)
                mdl_mem[(addr + k) % 4096] = 8'(wdata >> (8 * (n - 1 - k)));
            e.data   = mdl_held;
            e.lat    = n + 1;
            e.nbytes = n;
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++)
                v = (v << 8) | 32'(mdl_mem[(addr + k) % 4096]);
            if (mode == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            mdl_held = v;
            e.data   = v;
            e.lat    = n + 2;
            e.nbytes = n;
        end
        return e;
    endfunction

    // Called at a negedge. Presents a request, waits for acceptance, pushes
    // the expectation and returns at the negedge of T1.
    task automatic req(bit rd, bit wr, bit [1:0] mode, logic [31:0] addr,
                       logic [31:0] wdata, bit hold);
        int   budget;
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.load_mode  = mode;
        bus.address    = addr;
        bus.write_data = wdata;
        budget = 0;
        while (!bus.req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck low, addr %h", addr);
            bus.req_valid = 1'b0;
            return;
        end
        e     = model(rd, wr, mode, addr, wdata);
        e.acc = cyc;
        sbq.push_back(e);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((sbq.size() != 0 || !bus.req_ready) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (sbq.size() != 0 || !bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d responses outstanding", sbq.size());
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'h1);
        check({tag, "_ram_en"},     32'(ram_en),         32'h0);
        check({tag, "_ram_we"},     32'(ram_we),         32'h0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        check({tag, "_resp_err"},   32'(bus.resp_err),   32'h0);
        check({tag, "_ram_addr"},   ram_addr,            32'h0);
        check({tag, "_ram_wdata"},  32'(ram_wdata),      32'h0);
        check({tag, "_read_data"},  bus.read_data,       32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cnt = 0;
            end else begin
                if (ram_en) begin
                    en_cnt++;
                    check("ram_addr_range", 32'(ram_addr[31:12]), 32'h0);
                end
                if (bus.resp_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: err=%0b data=%h with none expected",
                                 bus.resp_err, bus.read_data);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_err",          32'(bus.resp_err),  32'(e.err));
                        check("read_data",         bus.read_data,      e.data);
                        check("resp_latency",      32'(cyc - e.acc),   32'(e.lat));
                        check("ram_en_cycles",     32'(en_cnt),        32'(e.nbytes));
                        check("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ndiff;
        mdl_held       = 32'h0;
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.load_mode  = 2'b00;
        bus.address    = '0;
        bus.write_data = '0;

        // Request held during reset must not be accepted.
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.mem_read  = 1'b1;
        bus.address   = 32'h100;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ram_en", 32'(ram_en), 32'h0);

        // Word store / load round trip.
        req(1'b0, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 1'b0);
        req(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0);
        wait_idle();
        check("ram_100", 32'(ram[32'h100]), 32'hDE);
        check("ram_101", 32'(ram[32'h101]), 32'hAD);
        check("ram_102", 32'(ram[32'h102]), 32'hBE);
        check("ram_103", 32'(ram[32'h103]), 32'hEF);

        // Halfword signed/unsigned loads of 0x80,0x01.
        req(1'b0, 1'b1, 2'b01, 32'h200, 32'h00008001, 1'b0);
        req(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 1'b0);
        wait_idle();

        // Half store uses write_data[15:0] only.
        req(1'b0, 1'b1, 2'b10, 32'h202, 32'h1234ABCD, 1'b0);
        wait_idle();
        check("ram_202", 32'(ram[32'h202]), 32'hAB);
        check("ram_203", 32'(ram[32'h203]), 32'hCD);
        check("ram_201", 32'(ram[32'h201]), 32'h01);
        check("ram_204", 32'(ram[32'h204]), 32'(mdl_mem[32'h204]));

        // Rejected requests.
        req(1'b1, 1'b0, 2'b00, 32'h101, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'b01, 32'h203, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 1'b0);
        req(1'b1, 1'b1, 2'b00, 32'h100, 32'h0, 1'b0);
        req(1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0);
        wait_idle();

        // Reset in the middle of a word store: only byte 0 lands.
        bus.req_valid  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.load_mode  = 2'b00;
        bus.address    = 32'h300;
        bus.write_data = 32'hCAFEF00D;
        check("rst_test_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_store_reset");
        @(negedge clk);
        en_cnt = 0;
        check("rst_ram_300", 32'(ram[32'h300]), 32'hCA);
        check("rst_ram_301", 32'(ram[32'h301]), 32'(mdl_mem[32'h301]));
        mdl_mem[32'h300] = 8'hCA;
        mdl_held = 32'h0;
        req(1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 1'b0);
        wait_idle();

        // req_valid held high across back-to-back loads.
        req(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b1);
        req(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 1'b1);
        req(1'b1, 1'b0, 2'b10, 32'h202, 32'h0, 1'b1);
        req(1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 1'b0);
        wait_idle();

        // Randomised mix.
        for (int i = 0; i < 120; i++) begin
            int          sel;
            bit          rd;
            bit          wr;
            bit [1:0]    mode;
            logic [31:0] addr;
            sel  = $urandom_range(0, 9);
            rd   = (sel >= 1 && sel <= 4) || (sel == 0 && $urandom_range(0, 1) == 1);
            wr   = (sel >= 5) || (sel == 0 && rd);
            mode = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 1023)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            else if (mode != 2'b00 && $urandom_range(0, 1) == 1) addr = addr + 32'd2;
            req(rd, wr, mode, addr, $urandom, (i != 119) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle();

        ndiff = 0;
        for (int a = 0; a < 4096; a++)
            if (ram[a] != mdl_mem[a]) ndiff++;
        check("ram_image_diff_bytes", 32'(ndiff), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
